// File: rtl/sea_round_scheduler.sv
// -----------------------------------------------------------------------------
// sea_round_scheduler
//
// Shares one SEA round datapath between two requester channels. The block
// grants one job at a time, round-robin, and runs it to completion on the
// external combinational round unit (eng_*) and key generator (kg_*). Round
// keys are expanded into kbuf so that decryption can replay them in reverse.
//
// Optional build macro: SEA_PERF_CNT_EN adds the jobs_done / busy_cycles
// performance counters. They are free-running and wrap at 2^32.
//
// Ports
//   clk, reset        clock, synchronous active-low reset
//   req_valid/ready   per-channel job handshake (2 channels)
//   req_mode          per-channel mode, 0 = encrypt, 1 = decrypt
//   req_data/key      per-channel data and master key, channel c at [c*W +: W]
//   req_rounds        per-channel round count, clamped to MAX_ROUNDS
//   eng_data/key/mode round-unit inputs, valid in ROUND only
//   eng_out           round-unit result
//   kg_in / kg_out    key generator input (always kreg) and next key
//   rsp_valid/ready   result handshake, rsp_id/rsp_data held until accepted
//   busy              a job is in progress
//   jobs_done         (SEA_PERF_CNT_EN) count of rsp handshakes
//   busy_cycles       (SEA_PERF_CNT_EN) count of cycles with busy = 1
// -----------------------------------------------------------------------------
module sea_round_scheduler #(
    parameter int DW         = 256,
    parameter int KW         = 256,
    parameter int MAX_ROUNDS = 64,
    parameter int RW         = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_mode,
    input  logic [2*DW-1:0] req_data,
    input  logic [2*KW-1:0] req_key,
    input  logic [2*RW-1:0] req_rounds,
    output logic [DW-1:0]   eng_data,
    output logic [KW-1:0]   eng_key,
    output logic            eng_mode,
    input  logic [DW-1:0]   eng_out,
    output logic [KW-1:0]   kg_in,
    input  logic [KW-1:0]   kg_out,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [DW-1:0]   rsp_data,
    output logic            busy
`ifdef SEA_PERF_CNT_EN
    ,
    output logic [31:0]     jobs_done,
    output logic [31:0]     busy_cycles
`endif
);

    localparam int IW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [DW-1:0]   data_r;
    logic [KW-1:0]   kreg_r;
    logic [RW-1:0]   cnt_r;
    logic [RW-1:0]   rounds_r;
    logic            mode_r;
    logic            id_r;
    logic            rr_ptr_r;
    logic [KW-1:0]   kbuf_r [MAX_ROUNDS];

    logic            grant_vld_s;
    logic            grant_s;
    logic [DW-1:0]   sel_data_s;
    logic [KW-1:0]   sel_key_s;
    logic [RW-1:0]   sel_rounds_s;
    logic [RW-1:0]   r_eff_s;
    logic            last_s;

    // Round-robin arbiter: grants only in IDLE, and never while reset is held.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = 1'b0;
        req_ready   = 2'b00;
        if ((state_r == ST_IDLE) && reset) begin
            if (req_valid == 2'b11) begin
                grant_vld_s = 1'b1;
                grant_s     = rr_ptr_r;
            end else if (req_valid[0]) begin
                grant_vld_s = 1'b1;
                grant_s     = 1'b0;
            end else if (req_valid[1]) begin
                grant_vld_s = 1'b1;
                grant_s     = 1'b1;
            end else begin
                grant_vld_s = 1'b0;
            end
        end else begin
            grant_vld_s = 1'b0;
        end
        if (grant_vld_s) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Select the granted channel's fields and clamp its round count.
    always_comb begin
        if (grant_s) begin
            sel_data_s   = req_data[2*DW-1:DW];
            sel_key_s    = req_key[2*KW-1:KW];
            sel_rounds_s = req_rounds[2*RW-1:RW];
        end else begin
            sel_data_s   = req_data[DW-1:0];
            sel_key_s    = req_key[KW-1:0];
            sel_rounds_s = req_rounds[RW-1:0];
        end
        if (sel_rounds_s > RW'(MAX_ROUNDS)) begin
            r_eff_s = RW'(MAX_ROUNDS);
        end else begin
            r_eff_s = sel_rounds_s;
        end
    end

    // Last-step detect: decrypt rounds count down to 0, everything else counts up.
    always_comb begin
        if ((state_r == ST_ROUND) && mode_r) begin
            last_s = (cnt_r == {RW{1'b0}});
        end else begin
            last_s = (cnt_r == (rounds_r - RW'(1)));
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!grant_vld_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (r_eff_s == {RW{1'b0}}) begin
                    state_nxt_s = ST_DONE;
                end else if (req_mode[grant_s]) begin
                    state_nxt_s = ST_KEYEXP;
                end else begin
                    state_nxt_s = ST_ROUND;
                end
            end
            ST_KEYEXP: begin
                if (last_s) begin
                    state_nxt_s = ST_ROUND;
                end else begin
                    state_nxt_s = ST_KEYEXP;
                end
            end
            ST_ROUND: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ROUND;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Job datapath: accept, key expansion, round iteration.
    // At the end of KEYEXP cnt is left at R-1, the first decrypt key index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_r   <= {DW{1'b0}};
            kreg_r   <= {KW{1'b0}};
            cnt_r    <= {RW{1'b0}};
            rounds_r <= {RW{1'b0}};
            mode_r   <= 1'b0;
            id_r     <= 1'b0;
            rr_ptr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        data_r   <= sel_data_s;
                        kreg_r   <= sel_key_s;
                        cnt_r    <= {RW{1'b0}};
                        rounds_r <= r_eff_s;
                        mode_r   <= req_mode[grant_s];
                        id_r     <= grant_s;
                        rr_ptr_r <= ~grant_s;
                    end
                end
                ST_KEYEXP: begin
                    kreg_r <= kg_out;
                    if (!last_s) begin
                        cnt_r <= cnt_r + RW'(1);
                    end
                end
                ST_ROUND: begin
                    data_r <= eng_out;
                    if (mode_r) begin
                        if (!last_s) begin
                            cnt_r <= cnt_r - RW'(1);
                        end
                    end else begin
                        kreg_r <= kg_out;
                        if (!last_s) begin
                            cnt_r <= cnt_r + RW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    data_r <= data_r;
                end
                default: begin
                    data_r <= data_r;
                end
            endcase
        end
    end

    // Round-key buffer, filled during KEYEXP; contents only matter in decrypt ROUND.
    always_ff @(posedge clk) begin
        if (state_r == ST_KEYEXP) begin
            kbuf_r[cnt_r[IW-1:0]] <= kreg_r;
        end
    end

    // Outputs decoded from registered state; zero outside the states that use them.
    always_comb begin
        eng_data  = {DW{1'b0}};
        eng_key   = {KW{1'b0}};
        eng_mode  = 1'b0;
        rsp_valid = 1'b0;
        rsp_id    = 1'b0;
        rsp_data  = {DW{1'b0}};
        kg_in     = kreg_r;
        busy      = (state_r != ST_IDLE);
        if (state_r == ST_ROUND) begin
            eng_data = data_r;
            eng_mode = mode_r;
            if (mode_r) begin
                eng_key = kbuf_r[cnt_r[IW-1:0]];
            end else begin
                eng_key = kreg_r;
            end
        end else if (state_r == ST_DONE) begin
            rsp_valid = 1'b1;
            rsp_id    = id_r;
            rsp_data  = data_r;
        end else begin
            eng_mode = 1'b0;
        end
    end

`ifdef SEA_PERF_CNT_EN
    // Performance counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            jobs_done   <= 32'd0;
            busy_cycles <= 32'd0;
        end else begin
            if ((state_r == ST_DONE) && rsp_ready) begin
                jobs_done <= jobs_done + 32'd1;
            end
            if (state_r != ST_IDLE) begin
                busy_cycles <= busy_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
